// File: rtl/obuf_accum_ctrl_if.sv
// Partial-sum input beat and flattened output-buffer bank ports for the accumulation controller.
// The controller connects through the slave modport. The array and buffer side connects through the master modport.
interface obuf_accum_ctrl_if #(
    parameter int NUM_TAGS        = 2,
    parameter int TAG_W           = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1,
    parameter int ARRAY_M         = 16,
    parameter int PSUM_WIDTH      = 32,
    parameter int OBUF_DATA_WIDTH = 32,
    parameter int OBUF_ADDR_WIDTH = 8
);
    logic                                            psum_valid;
    logic [TAG_W-1:0]                                psum_tag;
    logic [OBUF_ADDR_WIDTH-1:0]                      psum_addr;
    logic                                            psum_accum;
    logic [ARRAY_M*PSUM_WIDTH-1:0]                   psum_data;

    logic [NUM_TAGS*ARRAY_M-1:0]                     bs_read_req;
    logic [NUM_TAGS*ARRAY_M*OBUF_ADDR_WIDTH-1:0]     bs_read_addr;
    logic [NUM_TAGS*ARRAY_M*OBUF_DATA_WIDTH-1:0]     bs_read_data;
    logic [NUM_TAGS*ARRAY_M-1:0]                     bs_write_req;
    logic [NUM_TAGS*ARRAY_M*OBUF_ADDR_WIDTH-1:0]     bs_write_addr;
    logic [NUM_TAGS*ARRAY_M*OBUF_DATA_WIDTH-1:0]     bs_write_data;

    modport master (
        output psum_valid, psum_tag, psum_addr, psum_accum, psum_data, bs_read_data,
        input  bs_read_req, bs_read_addr, bs_write_req, bs_write_addr, bs_write_data
    );

    modport slave (
        input  psum_valid, psum_tag, psum_addr, psum_accum, psum_data, bs_read_data,
        output bs_read_req, bs_read_addr, bs_write_req, bs_write_addr, bs_write_data
    );
endinterface

// File: rtl/obuf_accum_ctrl.sv
// Three-stage read-modify-write accumulation controller between the systolic array and the output buffer.
// Stage S2 forwards from S3 and a one-entry write history so that back-to-back beats to one address stay correct.
module obuf_accum_ctrl #(
    parameter int NUM_TAGS        = 2,
    parameter int TAG_W           = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1,
    parameter int ARRAY_M         = 16,
    parameter int PSUM_WIDTH      = 32,
    parameter int OBUF_DATA_WIDTH = 32,
    parameter int OBUF_ADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    obuf_accum_ctrl_if.slave       bus,
    output logic                   pipe_idle,
    output logic [31:0]            beat_count
);
    localparam int M  = ARRAY_M;
    localparam int PW = PSUM_WIDTH;
    localparam int DW = OBUF_DATA_WIDTH;
    localparam int AW = OBUF_ADDR_WIDTH;
    localparam logic [TAG_W:0] TagLimit = (TAG_W+1)'(NUM_TAGS);

    logic              s1Valid_q, s1Valid_d;
    logic [TAG_W-1:0]  s1Tag_q,   s1Tag_d;
    logic [AW-1:0]     s1Addr_q,  s1Addr_d;
    logic              s1Accum_q, s1Accum_d;
    logic [M*PW-1:0]   s1Data_q,  s1Data_d;

    logic              s2Valid_q, s2Valid_d;
    logic [TAG_W-1:0]  s2Tag_q,   s2Tag_d;
    logic [AW-1:0]     s2Addr_q,  s2Addr_d;
    logic              s2Accum_q, s2Accum_d;
    logic [M*PW-1:0]   s2Data_q,  s2Data_d;

    logic              s3Valid_q, s3Valid_d;
    logic [TAG_W-1:0]  s3Tag_q,   s3Tag_d;
    logic [AW-1:0]     s3Addr_q,  s3Addr_d;
    logic [M*DW-1:0]   s3Data_q,  s3Data_d;

    logic              histValid_q, histValid_d;
    logic [TAG_W-1:0]  histTag_q,   histTag_d;
    logic [AW-1:0]     histAddr_q,  histAddr_d;
    logic [M*DW-1:0]   histData_q,  histData_d;

    logic [31:0]       beatCount_q, beatCount_d;

    logic              fwdS3;
    logic              fwdHist;
    logic [M*DW-1:0]   sumData;
    logic [DW-1:0]     rdLane;
    logic [DW-1:0]     oldLane;
    logic [DW-1:0]     psumExt;

    // The S3 match wins because its write is newer than the history entry.
    assign fwdS3   = s3Valid_q   && (s3Tag_q   == s2Tag_q) && (s3Addr_q   == s2Addr_q);
    assign fwdHist = histValid_q && (histTag_q == s2Tag_q) && (histAddr_q == s2Addr_q);

    always_comb begin
        sumData = '0;
        rdLane  = '0;
        oldLane = '0;
        psumExt = '0;
        for (int m = 0; m < M; m++) begin
            rdLane = '0;
            for (int n = 0; n < NUM_TAGS; n++) begin
                if (s2Tag_q == TAG_W'(n)) begin
                    rdLane = bus.bs_read_data[(n*M+m)*DW +: DW];
                end
            end
            if (fwdS3) begin
                oldLane = s3Data_q[m*DW +: DW];
            end else if (fwdHist) begin
                oldLane = histData_q[m*DW +: DW];
            end else begin
                oldLane = rdLane;
            end
            psumExt = DW'($signed(s2Data_q[m*PW +: PW]));
            sumData[m*DW +: DW] = s2Accum_q ? (oldLane + psumExt) : psumExt;
        end
    end

    // Beats with a tag beyond NUM_TAGS are dropped at acceptance.
    always_comb begin
        s1Valid_d   = bus.psum_valid && ({1'b0, bus.psum_tag} < TagLimit);
        s1Tag_d     = bus.psum_tag;
        s1Addr_d    = bus.psum_addr;
        s1Accum_d   = bus.psum_accum;
        s1Data_d    = bus.psum_data;

        s2Valid_d   = s1Valid_q;
        s2Tag_d     = s1Tag_q;
        s2Addr_d    = s1Addr_q;
        s2Accum_d   = s1Accum_q;
        s2Data_d    = s1Data_q;

        s3Valid_d   = s2Valid_q;
        s3Tag_d     = s2Tag_q;
        s3Addr_d    = s2Addr_q;
        s3Data_d    = sumData;

        histValid_d = s3Valid_q;
        histTag_d   = s3Tag_q;
        histAddr_d  = s3Addr_q;
        histData_d  = s3Data_q;

        beatCount_d = beatCount_q + 32'(s3Valid_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid_q   <= 1'b0;
            s1Tag_q     <= '0;
            s1Addr_q    <= '0;
            s1Accum_q   <= 1'b0;
            s1Data_q    <= '0;
            s2Valid_q   <= 1'b0;
            s2Tag_q     <= '0;
            s2Addr_q    <= '0;
            s2Accum_q   <= 1'b0;
            s2Data_q    <= '0;
            s3Valid_q   <= 1'b0;
            s3Tag_q     <= '0;
            s3Addr_q    <= '0;
            s3Data_q    <= '0;
            histValid_q <= 1'b0;
            histTag_q   <= '0;
            histAddr_q  <= '0;
            histData_q  <= '0;
            beatCount_q <= '0;
        end else begin
            s1Valid_q   <= s1Valid_d;
            s1Tag_q     <= s1Tag_d;
            s1Addr_q    <= s1Addr_d;
            s1Accum_q   <= s1Accum_d;
            s1Data_q    <= s1Data_d;
            s2Valid_q   <= s2Valid_d;
            s2Tag_q     <= s2Tag_d;
            s2Addr_q    <= s2Addr_d;
            s2Accum_q   <= s2Accum_d;
            s2Data_q    <= s2Data_d;
            s3Valid_q   <= s3Valid_d;
            s3Tag_q     <= s3Tag_d;
            s3Addr_q    <= s3Addr_d;
            s3Data_q    <= s3Data_d;
            histValid_q <= histValid_d;
            histTag_q   <= histTag_d;
            histAddr_q  <= histAddr_d;
            histData_q  <= histData_d;
            beatCount_q <= beatCount_d;
        end
    end

    // Bank ports are gated by reset so an in-flight beat never writes during the reset cycle.
    always_comb begin
        bus.bs_read_req   = '0;
        bus.bs_read_addr  = '0;
        bus.bs_write_req  = '0;
        bus.bs_write_addr = '0;
        bus.bs_write_data = '0;
        for (int n = 0; n < NUM_TAGS; n++) begin
            if (!reset && s1Valid_q && s1Accum_q && (s1Tag_q == TAG_W'(n))) begin
                bus.bs_read_req[n*M +: M] = {M{1'b1}};
                for (int m = 0; m < M; m++) begin
                    bus.bs_read_addr[(n*M+m)*AW +: AW] = s1Addr_q;
                end
            end
            if (!reset && s3Valid_q && (s3Tag_q == TAG_W'(n))) begin
                bus.bs_write_req[n*M +: M] = {M{1'b1}};
                for (int m = 0; m < M; m++) begin
                    bus.bs_write_addr[(n*M+m)*AW +: AW] = s3Addr_q;
                    bus.bs_write_data[(n*M+m)*DW +: DW] = s3Data_q[m*DW +: DW];
                end
            end
        end
    end

    assign pipe_idle  = !(s1Valid_q || s2Valid_q || s3Valid_q);
    assign beat_count = beatCount_q;

endmodule

// File: doc/obuf_accum_ctrl.md
Name: obuf_accum_ctrl

Overview:
- Read-modify-write accumulation controller between the systolic array outputs and the multi-tag output buffer.
- Each accepted partial-sum beat (ARRAY_M lanes, one shared address, one tag) is either written straight into the selected tag's banks or added to the stored value.
- Forwarding inside the pipeline keeps back-to-back beats to the same address correct.
- Drives the output buffer's flattened bank read/write ports directly: tag n owns slice n, lane m owns bank m of that slice.

Parameters:
NUM_TAGS, 2, number of output-buffer tags (bank groups)
TAG_W, $clog2(NUM_TAGS) (min 1), tag index width
ARRAY_M, 16, lanes / banks per tag
PSUM_WIDTH, 32, signed partial-sum width per lane from the array
OBUF_DATA_WIDTH, 32, stored word width per bank; equals read and write width
OBUF_ADDR_WIDTH, 8, bank address width, shared by read and write

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
psum_valid  in  1  beat valid
psum_tag  in  TAG_W  destination tag
psum_addr  in  OBUF_ADDR_WIDTH  bank address, common to all lanes
psum_accum  in  1  1 = add to stored value, 0 = overwrite
psum_data  in  ARRAY_M*PSUM_WIDTH  signed lane data, lane m at [m*PSUM_WIDTH +: PSUM_WIDTH]
bs_read_req  out  NUM_TAGS*ARRAY_M  per-bank read request
bs_read_addr  out  NUM_TAGS*ARRAY_M*OBUF_ADDR_WIDTH  per-bank read address
bs_read_data  in  NUM_TAGS*ARRAY_M*OBUF_DATA_WIDTH  per-bank read data, valid one cycle after req
bs_write_req  out  NUM_TAGS*ARRAY_M  per-bank write request
bs_write_addr  out  NUM_TAGS*ARRAY_M*OBUF_ADDR_WIDTH  per-bank write address
bs_write_data  out  NUM_TAGS*ARRAY_M*OBUF_DATA_WIDTH  per-bank write data
pipe_idle  out  1  no beat in flight
beat_count  out  32  number of writes committed since reset (wraps)

Behaviour:
- No backpressure: a beat is accepted on every cycle psum_valid=1.
- Pipeline: S1 registers the beat. S2 holds it while read data returns. S3 registers the write.
- Beat accepted at cycle t:
  - Read issued at t+1, only if psum_accum=1.
  - Read data sampled at t+2.
  - Write asserted at t+3.
  - Accept-to-write latency is fixed at 3 for both modes.
- Read request asserts only the ARRAY_M bits of slice psum_tag; all other slices read 0. bs_read_addr replicates the address into every lane of that slice; other slices' addresses are don't-care, driven 0.
- Write request asserts all ARRAY_M bits of the tag slice for exactly one cycle per beat.
- Arithmetic per lane:
  - psum sign-extended (or truncated) to OBUF_DATA_WIDTH.
  - sum = old + psum, two's-complement wrap, no saturation.
  - Overwrite mode writes the extended psum.
- Forwarding (S2 old-value select, per lane, highest priority first):
  1. S3 beat with same tag and addr → use S3 write data. This covers the write landing in the same cycle data is sampled.
  2. Prior beat to same tag and addr, committed in the cycle of this beat's S1 read → use that beat's written data, kept in a one-entry write-history register.
  3. Otherwise → bs_read_data slice.
- Any tag/addr mismatch disables forwarding.
- Overwrite beats ignore old data entirely.
- Read and write to different tags or addresses in the same cycle are independent.
- pipe_idle = 1 iff S1, S2 and S3 valid are all 0.
- beat_count increments on each cycle any write is issued; 32-bit wrap.
- Reset: all outputs 0 except pipe_idle=1. All stage valids and the history register are cleared.
- A reset asserted mid-flight drops every in-flight beat: no write is issued on the reset cycle or after it.
- Address 2^OBUF_ADDR_WIDTH-1 and tag NUM_TAGS-1 have no special handling.
- Out-of-range tag values (NUM_TAGS not a power of 2) are dropped: no read, no write, not counted.

Test Plan:
- Single overwrite beat, tag 0, addr 5, lane m data = m:
  - no read issued;
  - write at t+3 on slice 0, addr 5, data m;
  - beat_count=1; pipe_idle back to 1 at t+4.
- Accumulate to tag 1, addr 3, memory model holding 100 in every lane, psum = -1 in every lane → one read at t+1 on slice 1 only; write at t+3 with 99 in every lane.
- Back-to-back accumulate beats to tag 0, addr 7 on 3 consecutive cycles, each +1, memory holding 10 → writes 11, 12, 13 at t+3, t+4, t+5.
- Beats to addr 7 at t and t+2 (gap of one cycle), +5 each, memory 0 → history forwarding yields writes 5, then 10.
- Same addr 2 but different tags on consecutive cycles → no forwarding; each tag's write uses its own read data.
- Wrap: stored 0xFFFFFFFF + psum 1 → 0. Reset asserted at t+2 of an in-flight beat → no write ever issued; all outputs 0; pipe_idle=1.
